// File: rtl/pong_pkg.sv
// Shared Pong definitions: game state encoding, score digit width and serve counter width.
package pong_pkg;
   localparam int SCORE_W           = 4;
   localparam int WIN_SCORE_DEFAULT = 7;
   localparam int SERVE_CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE     = 2'd1,
      PLAY      = 2'd2,
      GAME_OVER = 2'd3
   } state_t;
endpackage

// File: rtl/score_keeper_if.sv
// Bundle between the score keeper and its neighbours (sync gen, ball logic, renderer).
// Inputs are level or single-cycle pulses sampled on clock; outputs are registered.
interface score_keeper_if;
   import pong_pkg::*;

   logic                frame_tick;
   logic                goal_left;
   logic                goal_right;
   logic                start;
   logic [SCORE_W-1:0]  score_p1;
   logic [SCORE_W-1:0]  score_p2;
   logic                serve_hold;
   logic                game_over;
   logic                winner;
   state_t              state;

   modport slave (
      input  frame_tick, goal_left, goal_right, start,
      output score_p1, score_p2, serve_hold, game_over, winner, state
   );

   modport master (
      output frame_tick, goal_left, goal_right, start,
      input  score_p1, score_p2, serve_hold, game_over, winner, state
   );
endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector: one history flop plus an AND gate.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic rise
);
   logic levelQ;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) levelQ <= 1'b0;
      else       levelQ <= level;
   end

   assign rise = level & ~levelQ;
endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: counts points on goal rises and sequences serve delay,
// game over and restart. All outputs are registered.
module score_keeper
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = WIN_SCORE_DEFAULT,
   parameter int SERVE_FRAMES = 60
) (
   input  logic           clock,
   input  logic           reset,
   score_keeper_if.slave  bus
);
   localparam logic [SCORE_W-1:0]     WIN_VAL    = SCORE_W'(WIN_SCORE);
   localparam logic [SERVE_CNT_W-1:0] SERVE_LOAD = SERVE_CNT_W'(SERVE_FRAMES);

   state_t                 state;
   logic [SERVE_CNT_W-1:0] serveCount;
   logic [SCORE_W-1:0]     scoreP1, scoreP2, scoreP1Inc, scoreP2Inc;
   logic                   serveHold, gameOver, winner;
   logic                   riseLeft, riseRight;

   rise_detect uRiseLeft  (.clock(clock), .reset(reset), .level(bus.goal_left),  .rise(riseLeft));
   rise_detect uRiseRight (.clock(clock), .reset(reset), .level(bus.goal_right), .rise(riseRight));

   assign scoreP1Inc = scoreP1 + 1'b1;
   assign scoreP2Inc = scoreP2 + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         serveCount <= '0;
         scoreP1    <= '0;
         scoreP2    <= '0;
         serveHold  <= 1'b1;
         gameOver   <= 1'b0;
         winner     <= 1'b0;
      end else if (bus.start) begin
         // A new game starts from any state and overrides a coincident goal.
         state      <= SERVE;
         serveCount <= SERVE_LOAD;
         scoreP1    <= '0;
         scoreP2    <= '0;
         serveHold  <= 1'b1;
         gameOver   <= 1'b0;
         winner     <= 1'b0;
      end else begin
         case (state)
            SERVE: begin
               if (bus.frame_tick) begin
                  serveCount <= serveCount - 1'b1;
                  if (serveCount == SERVE_CNT_W'(1)) begin
                     state     <= PLAY;
                     serveHold <= 1'b0;
                  end
               end
            end
            PLAY: begin
               if (riseLeft || riseRight) begin
                  serveHold  <= 1'b1;
                  serveCount <= SERVE_LOAD;
                  state      <= SERVE;
                  // Simultaneous goals are a void point: re-serve with no score.
                  if (riseLeft && !riseRight) begin
                     scoreP2 <= scoreP2Inc;
                     if (scoreP2Inc == WIN_VAL) begin
                        state    <= GAME_OVER;
                        gameOver <= 1'b1;
                        winner   <= 1'b1;
                     end
                  end else if (riseRight && !riseLeft) begin
                     scoreP1 <= scoreP1Inc;
                     if (scoreP1Inc == WIN_VAL) begin
                        state    <= GAME_OVER;
                        gameOver <= 1'b1;
                        winner   <= 1'b0;
                     end
                  end
               end
            end
            default: ; // IDLE and GAME_OVER wait for start
         endcase
      end
   end

   assign bus.score_p1   = scoreP1;
   assign bus.score_p2   = scoreP2;
   assign bus.serve_hold = serveHold;
   assign bus.game_over  = gameOver;
   assign bus.winner     = winner;
   assign bus.state      = state;
endmodule

// File: tb/tb_score_keeper.sv
// Scenario bench for score_keeper: expected output words are queued as stimulus
// is driven and popped against the DUT after the clock edge that produces them.
module tb_score_keeper;
   import pong_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   assertCount = 0;
   int   failCount   = 0;

   // {state, score_p1, score_p2, serve_hold, game_over, winner}
   logic [12:0] expQ[$];
   logic [12:0] got, expv;

   score_keeper_if bus ();

   score_keeper #(.WIN_SCORE(7), .SERVE_FRAMES(60)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus.slave)
   );

   always #5 clock = ~clock;

   function automatic logic [12:0] packExp(state_t s, int p1, int p2, bit h, bit g, bit w);
      return {s, 4'(p1), 4'(p2), h, g, w};
   endfunction

   function automatic logic [12:0] observed();
      return {bus.state, bus.score_p1, bus.score_p2, bus.serve_hold, bus.game_over, bus.winner};
   endfunction

   // Drive one cycle of inputs, then sample 1 ns after the edge.
   task automatic driveCycle(bit st, bit gl, bit gr, bit ft);
      bus.start = st; bus.goal_left = gl; bus.goal_right = gr; bus.frame_tick = ft;
      @(posedge clock);
      #1;
   endtask

   task automatic serveTicks(int n);
      for (int i = 0; i < n; i++) begin
         driveCycle(0, 0, 0, 1);
         driveCycle(0, 0, 0, 0);
      end
   endtask

   task automatic test_reset();
      bus.start = 0; bus.goal_left = 0; bus.goal_right = 0; bus.frame_tick = 0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #3 reset = 1'b0;
      expQ.push_back(packExp(IDLE, 0, 0, 1, 0, 0));
      driveCycle(0, 0, 0, 1);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL reset_state: got %h expected %h", got, expv); end
   endtask

   task automatic test_serve_delay();
      expQ.push_back(packExp(SERVE, 0, 0, 1, 0, 0));
      driveCycle(1, 0, 0, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL start_idle: got %h expected %h", got, expv); end
      expQ.push_back(packExp(SERVE, 0, 0, 1, 0, 0));
      serveTicks(59);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL serve_59_ticks: got %h expected %h", got, expv); end
      expQ.push_back(packExp(PLAY, 0, 0, 0, 0, 0));
      driveCycle(0, 0, 0, 1);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL serve_60th_tick: got %h expected %h", got, expv); end
      driveCycle(0, 0, 0, 0);
   endtask

   task automatic test_held_goal();
      expQ.push_back(packExp(SERVE, 1, 0, 1, 0, 0));
      driveCycle(0, 0, 1, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL held_goal_first: got %h expected %h", got, expv); end
      expQ.push_back(packExp(SERVE, 1, 0, 1, 0, 0));
      repeat (49) driveCycle(0, 0, 1, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL held_goal_50: got %h expected %h", got, expv); end
      driveCycle(0, 0, 0, 0);
      serveTicks(60);
   endtask

   task automatic test_double_goal();
      expQ.push_back(packExp(SERVE, 1, 0, 1, 0, 0));
      driveCycle(0, 1, 1, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL double_goal: got %h expected %h", got, expv); end
      driveCycle(0, 0, 0, 0);
      expQ.push_back(packExp(PLAY, 1, 0, 0, 0, 0));
      serveTicks(60);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL double_goal_resume: got %h expected %h", got, expv); end
   endtask

   task automatic test_game_over();
      for (int i = 1; i <= 6; i++) begin
         expQ.push_back(packExp(SERVE, 1, i, 1, 0, 0));
         driveCycle(0, 1, 0, 0);
         got = observed(); expv = expQ.pop_front(); assertCount++;
         if (got !== expv) begin failCount++; $display("FAIL left_goal_%0d: got %h expected %h", i, got, expv); end
         driveCycle(0, 0, 0, 0);
         serveTicks(60);
      end
      expQ.push_back(packExp(GAME_OVER, 1, 7, 1, 1, 1));
      driveCycle(0, 1, 0, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL winning_goal: got %h expected %h", got, expv); end
      driveCycle(0, 0, 0, 0);
      expQ.push_back(packExp(GAME_OVER, 1, 7, 1, 1, 1));
      driveCycle(0, 1, 0, 1);
      driveCycle(0, 0, 0, 1);
      driveCycle(0, 0, 1, 0);
      serveTicks(5);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL game_over_frozen: got %h expected %h", got, expv); end
   endtask

   task automatic test_new_game();
      expQ.push_back(packExp(SERVE, 0, 0, 1, 0, 0));
      driveCycle(1, 0, 0, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL new_game: got %h expected %h", got, expv); end
   endtask

   task automatic test_async_reset();
      serveTicks(60);
      for (int i = 1; i <= 3; i++) begin
         driveCycle(0, 0, 1, 0);
         driveCycle(0, 0, 0, 0);
         serveTicks(60);
      end
      expQ.push_back(packExp(PLAY, 3, 0, 0, 0, 0));
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL play_p1_3: got %h expected %h", got, expv); end
      #3 reset = 1'b1;
      #1;
      expQ.push_back(packExp(IDLE, 0, 0, 1, 0, 0));
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL async_reset: got %h expected %h", got, expv); end
      @(posedge clock);
      #3 reset = 1'b0;
      @(posedge clock);
      #1;
      expQ.push_back(packExp(IDLE, 0, 0, 1, 0, 0));
      driveCycle(0, 1, 0, 0);
      driveCycle(0, 0, 0, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL idle_goal_ignored: got %h expected %h", got, expv); end
   endtask

   task automatic test_restart();
      driveCycle(1, 0, 0, 0);
      serveTicks(30);
      expQ.push_back(packExp(SERVE, 0, 0, 1, 0, 0));
      driveCycle(1, 0, 0, 0);
      serveTicks(59);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL restart_reload: got %h expected %h", got, expv); end
      expQ.push_back(packExp(PLAY, 0, 0, 0, 0, 0));
      driveCycle(0, 0, 0, 1);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL restart_play: got %h expected %h", got, expv); end
      expQ.push_back(packExp(SERVE, 0, 0, 1, 0, 0));
      driveCycle(1, 1, 0, 0);
      got = observed(); expv = expQ.pop_front(); assertCount++;
      if (got !== expv) begin failCount++; $display("FAIL start_beats_goal: got %h expected %h", got, expv); end
      driveCycle(0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_serve_delay();
      test_held_goal();
      test_double_goal();
      test_game_over();
      test_new_game();
      test_async_reset();
      test_restart();
      if (expQ.size() != 0) begin
         failCount++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
